// File: rtl/spi_duty_receiver_if.sv
// SPI bus bundle between the board Master and the duty-cycle receiver.
// Signals:
//   sclk - SPI clock, driven by the master
//   cs_n - chip select, active low, driven by the master
//   mosi - master-to-slave data, MSB first
//   miso - slave-to-master data, MSB first (no tristate; board ORs slaves)
interface spi_duty_receiver_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_duty_receiver.sv
// SPI mode-0 slave that receives 8-bit command frames and holds the 4-bit
// duty_cycle value feeding the PWM generator. All SPI pins are oversampled
// in the clk domain; a status byte {duty_cycle, 3'b000, err_flag} is shifted
// back on miso during every frame.
// Ports:
//   clk        - system clock (sclk must be at most clk/8)
//   rst_n      - asynchronous active-low reset
//   spi        - SPI bus (slave modport): sclk, cs_n, mosi in; miso out
//   duty_cycle - registered duty value, changes only when a frame commits
//   duty_valid - one-clk pulse in the cycle a write frame commits
//   frame_err  - one-clk pulse in the cycle a frame is rejected
module spi_duty_receiver #(
  parameter int          SYNC_STAGES = 2,     // 2 or 3
  parameter logic [3:0]  WRITE_CMD   = 4'hA,
  parameter logic [3:0]  READ_CMD    = 4'h5,
  parameter logic [3:0]  RESET_DUTY  = 4'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_duty_receiver_if.slave   spi,
  output logic [3:0]           duty_cycle,
  output logic                 duty_valid,
  output logic                 frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Bit order of the synchronizer bundle: {mosi, cs_n, sclk}.
  // cs_n idles high so its chain resets to 1.
  localparam logic [2:0] SYNC_RST = 3'b010;

  logic [2:0] pin_async;
  logic [2:0] pin_sync;

  assign pin_async = {spi.mosi, spi.cs_n, spi.sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_async[gi]};
        end
      end

      assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic sclk_sync, cs_sync, mosi_sync;
  logic sclk_dly_reg, cs_dly_reg;
  logic sclk_rise, sclk_fall, cs_rise;

  assign sclk_sync = pin_sync[0];
  assign cs_sync   = pin_sync[1];
  assign mosi_sync = pin_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_dly_reg <= 1'b0;
      cs_dly_reg   <= 1'b1;
    end else begin
      sclk_dly_reg <= sclk_sync;
      cs_dly_reg   <= cs_sync;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_dly_reg;
  assign sclk_fall = ~sclk_sync & sclk_dly_reg;
  assign cs_rise   = cs_sync & ~cs_dly_reg;

  state_t     state_reg, state_next;
  logic [3:0] bit_cnt_reg;
  logic [7:0] rx_shift_reg;
  logic [7:0] tx_shift_reg;
  logic [3:0] duty_reg;
  logic       err_flag_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus the commit decode. The pulses are decoded from the
  // frame registers while in COMMIT, so they last exactly that one cycle.
  always_comb begin
    state_next = state_reg;
    duty_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        // Level check rather than edge: a falling cs_n that landed while
        // COMMIT was busy still starts the next frame here.
        if (!cs_sync) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        state_next = IDLE;
        if (bit_cnt_reg == 4'd8 && rx_shift_reg[7:4] == WRITE_CMD) begin
          duty_valid = 1'b1;
        end else if (bit_cnt_reg == 4'd8 && rx_shift_reg[7:4] == READ_CMD) begin
          duty_valid = 1'b0;
        end else begin
          frame_err = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg  <= 4'd0;
      rx_shift_reg <= 8'd0;
      tx_shift_reg <= 8'd0;
      duty_reg     <= RESET_DUTY;
      err_flag_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!cs_sync) begin
            bit_cnt_reg  <= 4'd0;
            rx_shift_reg <= 8'd0;
            tx_shift_reg <= {duty_reg, 3'b000, err_flag_reg};
          end
        end
        SHIFT: begin
          // A sample that coincides with cs_rise is still taken here, in
          // the same edge that moves the FSM into COMMIT.
          if (sclk_rise) begin
            rx_shift_reg <= {rx_shift_reg[6:0], mosi_sync};
            if (bit_cnt_reg != 4'd9) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
          // Bit 7 is presented at frame start; only falls after bits 1..7
          // advance the status byte, so the 8th fall leaves it alone.
          if (sclk_fall && bit_cnt_reg >= 4'd1 && bit_cnt_reg <= 4'd7) begin
            tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
          end
        end
        COMMIT: begin
          if (duty_valid) begin
            duty_reg     <= rx_shift_reg[3:0];
            err_flag_reg <= 1'b0;
          end else if (frame_err) begin
            err_flag_reg <= 1'b1;
          end else begin
            err_flag_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // miso follows the status MSB only inside a frame and is 0 otherwise.
  assign spi.miso   = (state_reg == SHIFT) ? tx_shift_reg[7] : 1'b0;
  assign duty_cycle = duty_reg;

endmodule

// File: tb/tb_spi_duty_receiver.sv
module tb_spi_duty_receiver;

  localparam int         HALF       = 8;     // clk cycles per half sclk period
  localparam logic [3:0] WRITE_CMD  = 4'hA;
  localparam logic [3:0] READ_CMD   = 4'h5;
  localparam logic [3:0] RESET_DUTY = 4'h0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] duty_cycle;
  logic       duty_valid;
  logic       frame_err;

  spi_duty_receiver_if spi_bus ();

  spi_duty_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi_bus),
    .duty_cycle (duty_cycle),
    .duty_valid (duty_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what the receiver should hold between frames.
  logic [3:0] m_duty = RESET_DUTY;
  logic       m_err  = 1'b0;

  // Expected pulses: {kind[1:0], duty after commit}; kind 1 = write, 2 = error.
  logic [5:0]  exp_q[$];
  // Expected miso bytes {mask, value} and the bytes the master captured.
  logic [15:0] miso_exp_q[$];
  logic [7:0]  miso_obs_q[$];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: checks every pulse against the scoreboard and the miso bytes.
  initial begin
    logic [5:0]  e;
    logic [15:0] me;
    logic [7:0]  mo;
    forever begin
      @(negedge clk);
      if (duty_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {frame_err, duty_valid}, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {frame_err, duty_valid}, e[5:4]);
          @(negedge clk);
          check("duty_after_pulse", duty_cycle, e[3:0]);
        end
      end
      if (miso_obs_q.size() != 0 && miso_exp_q.size() != 0) begin
        me = miso_exp_q.pop_front();
        mo = miso_obs_q.pop_front();
        check("miso_byte", mo, me[7:0]);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Drive one frame of nbits bits, MSB first, from data[nbits-1:0].
  // abort_at >= 0 asserts rst_n just before that bit index.
  task automatic do_frame(input logic [15:0] data, input int nbits, input int abort_at);
    logic [7:0] exp_miso, got_miso, mask, rx;
    exp_miso = {m_duty, 3'b000, m_err};
    got_miso = 8'h00;
    mask     = (nbits >= 8) ? 8'hFF : ~(8'hFF >> nbits);
    if (abort_at < 0) begin
      rx = data[7:0];
      if (nbits == 8 && rx[7:4] == WRITE_CMD) begin
        m_duty = rx[3:0];
        m_err  = 1'b0;
        exp_q.push_back({2'b01, m_duty});
      end else if (nbits == 8 && rx[7:4] == READ_CMD) begin
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
        exp_q.push_back({2'b10, m_duty});
      end
    end
    spi_bus.cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_duty", duty_cycle, RESET_DUTY);
        check("abort_pulses", {frame_err, duty_valid}, 0);
        check("abort_miso", spi_bus.miso, 0);
        m_duty = RESET_DUTY;
        m_err  = 1'b0;
        spi_bus.cs_n = 1'b1;
        spi_bus.sclk = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(2 * HALF);
        $display("frame data=%0h bits=%0d aborted by reset at bit %0d duty=%0h",
                 data, nbits, abort_at, duty_cycle);
        return;
      end
      spi_bus.mosi = data[nbits-1-i];
      tick(HALF);
      spi_bus.sclk = 1'b1;
      if (i < 8) got_miso[7-i] = spi_bus.miso;
      tick(HALF);
      spi_bus.sclk = 1'b0;
    end
    tick(HALF);
    spi_bus.cs_n = 1'b1;
    miso_exp_q.push_back({mask, exp_miso & mask});
    miso_obs_q.push_back(got_miso & mask);
    tick(2 * HALF);
    check("duty_after_frame", duty_cycle, m_duty);
    $display("frame data=%0h bits=%0d miso=%02h duty=%0h err_flag=%0b",
             data, nbits, got_miso, duty_cycle, m_err);
  endtask

  initial begin
    logic [15:0] d;
    int          nb;
    logic [3:0]  op;

    rst_n        = 1'b0;
    spi_bus.sclk = 1'b0;
    spi_bus.cs_n = 1'b1;
    spi_bus.mosi = 1'b0;
    tick(5);
    check("reset_duty", duty_cycle, RESET_DUTY);
    check("reset_pulses", {frame_err, duty_valid}, 0);
    check("reset_miso", spi_bus.miso, 0);
    rst_n = 1'b1;
    tick(5);

    do_frame(16'h00A5, 8, -1);        // write 5, status 00
    do_frame(16'h00AF, 8, -1);        // write F
    do_frame(16'h005C, 8, -1);        // read: status F0, no pulse
    do_frame(16'h0051, 7, -1);        // 8'hA2 truncated to 7 bits
    do_frame(16'h0050, 8, -1);        // read: status F1, err clears
    do_frame(16'h0037, 8, -1);        // unknown opcode
    do_frame(16'h01A5, 9, -1);        // 9-bit frame
    do_frame(16'h00A2, 8, -1);        // back-to-back writes
    do_frame(16'h00A1, 8, -1);
    do_frame(16'h00AA, 8, -1);

    // sclk/mosi activity with cs_n high must be ignored
    for (int k = 0; k < 12; k++) begin
      spi_bus.mosi = 1'($urandom_range(0, 1));
      spi_bus.sclk = ~spi_bus.sclk;
      tick(2);
    end
    spi_bus.sclk = 1'b0;
    tick(8);
    check("glitch_duty", duty_cycle, m_duty);

    do_frame(16'h00AF, 8, 4);         // reset lands at bit 4
    do_frame(16'h00A5, 8, -1);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 5))
        4:       nb = 7;
        5:       nb = 9;
        default: nb = 8;
      endcase
      case ($urandom_range(0, 2))
        0:       op = WRITE_CMD;
        1:       op = READ_CMD;
        default: op = 4'($urandom_range(0, 15));
      endcase
      d = 16'($urandom_range(0, 511));
      if (nb == 8) d = {8'h00, op, d[3:0]};
      else if (nb == 7) d = {9'h000, d[6:0]};
      do_frame(d, nb, -1);
    end

    tick(20);
    check("pulses_left_over", exp_q.size(), 0);
    check("miso_left_over", miso_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
